// File: rtl/decoder_pkg.sv
// Shared constants, symbol tags and tag-to-length lookup for the symbol decoder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package decoder_pkg;

   localparam int WORD_W  = 20;
   localparam int VALUE_W = 8;
   localparam int BUF_W   = 2 * WORD_W;
   localparam int LEN_W   = 4;

   localparam logic [1:0] TAG_ZERO   = 2'b00;
   localparam logic [1:0] TAG_SHORT  = 2'b01;
   localparam logic [1:0] TAG_LONG   = 2'b10;
   localparam logic [1:0] TAG_REPEAT = 2'b11;

   localparam logic [LEN_W-1:0] LEN_ZERO   = 4'd2;
   localparam logic [LEN_W-1:0] LEN_SHORT  = 4'd6;
   localparam logic [LEN_W-1:0] LEN_LONG   = 4'd10;
   localparam logic [LEN_W-1:0] LEN_REPEAT = 4'd2;

   // Total symbol length in bits, tag included.
   function automatic logic [LEN_W-1:0] sym_len(input logic [1:0] tag);
      logic [LEN_W-1:0] len;
      case (tag)
         TAG_SHORT:  len = LEN_SHORT;
         TAG_LONG:   len = LEN_LONG;
         TAG_REPEAT: len = LEN_REPEAT;
         default:    len = LEN_ZERO;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/decoder_bitbuf.sv
// LSB-first bit buffer with fill counter: shift-out of consumed bits and word append.
// Latency: shift and append take effect on the same rising edge.
// Backpressure: none here; the caller only appends when fill leaves room for a word.
module decoder_bitbuf #(
   parameter int WORD_W = 20,
   parameter int BUF_W  = 40,
   parameter int HEAD_W = 10,
   parameter int LEN_W  = 4,
   parameter int FILL_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              shift_en,
   input  logic [LEN_W-1:0]  shift_len,
   input  logic              app_en,
   input  logic [WORD_W-1:0] app_dat,
   output logic [HEAD_W-1:0] head,
   output logic [FILL_W-1:0] fill
);

   logic [BUF_W-1:0]  bits_q;
   logic [BUF_W-1:0]  bits_d;
   logic [BUF_W-1:0]  shifted;
   logic [FILL_W-1:0] fill_q;
   logic [FILL_W-1:0] fill_d;
   logic [FILL_W-1:0] fill_s;
   logic [LEN_W-1:0]  shamt;

   // Shift first, then place the new word right after the surviving bits so the
   // buffer stays contiguous; bits at and above fill are always zero.
   always_comb begin
      shamt = '0;
      if (shift_en) begin
         shamt = shift_len;
      end
      shifted = bits_q >> shamt;
      fill_s  = fill_q - FILL_W'(shamt);
      bits_d  = shifted;
      fill_d  = fill_s;
      if (app_en) begin
         bits_d = shifted | (BUF_W'(app_dat) << fill_s);
         fill_d = fill_s + FILL_W'(WORD_W);
      end
   end

   // Buffer and fill registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bits_q <= '0;
         fill_q <= '0;
      end else begin
         bits_q <= bits_d;
         fill_q <= fill_d;
      end
   end

   assign head = bits_q[HEAD_W-1:0];
   assign fill = fill_q;

endmodule

// File: rtl/decoder.sv
// Streaming variable-length symbol decoder: 20-bit words in, one 8-bit value per read.
// Latency: value updates on the read edge when the symbol is buffered, else one edge after it completes.
// Backpressure: req drops while fewer than WORD_W bits are free; words written then are dropped.
module decoder
   import decoder_pkg::*;
#(
   parameter int WORD_W  = decoder_pkg::WORD_W,
   parameter int VALUE_W = decoder_pkg::VALUE_W,
   parameter int BUF_W   = decoder_pkg::BUF_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WORD_W-1:0]  mem,
   input  logic               read,
   input  logic               write,
   output logic               req,
   output logic [VALUE_W-1:0] value
);

   localparam int HEAD_W = VALUE_W + 2;
   localparam int FILL_W = $clog2(BUF_W + 1);

   logic [HEAD_W-1:0]  head;
   logic [FILL_W-1:0]  fill;
   logic [1:0]         tag;
   logic [LEN_W-1:0]   len;
   logic               complete;
   logic               want;
   logic               dec;
   logic               room;
   logic               pending;
   logic [VALUE_W-1:0] sym_val;
   logic [VALUE_W-1:0] value_q;
   logic [VALUE_W-1:0] last_q;

   assign tag      = head[1:0];
   assign len      = sym_len(tag);
   // The tag itself is only trustworthy once two bits are buffered.
   assign complete = (fill >= FILL_W'(LEN_ZERO)) && (fill >= FILL_W'(len));
   assign want     = read | pending;
   assign dec      = want & complete;
   assign room     = (fill <= FILL_W'(BUF_W - WORD_W));

   decoder_bitbuf #(
      .WORD_W (WORD_W),
      .BUF_W  (BUF_W),
      .HEAD_W (HEAD_W),
      .LEN_W  (LEN_W),
      .FILL_W (FILL_W)
   ) u_bitbuf (
      .clk       (clk),
      .rst       (reset),
      .shift_en  (dec),
      .shift_len (len),
      .app_en    (write & room),
      .app_dat   (mem),
      .head      (head),
      .fill      (fill)
   );

   // Value carried by the symbol at the head of the buffer.
   always_comb begin
      sym_val = '0;
      case (tag)
         TAG_SHORT:  sym_val = VALUE_W'(head[5:2]);
         TAG_LONG:   sym_val = head[VALUE_W+1:2];
         TAG_REPEAT: sym_val = last_q;
         default:    sym_val = '0;
      endcase
   end

   // Decode when a read (new or waiting) meets a complete symbol; otherwise hold the read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= 1'b0;
         last_q  <= '0;
         value_q <= '0;
      end else begin
         if (dec) begin
            value_q <= sym_val;
            last_q  <= sym_val;
            pending <= 1'b0;
         end else if (want) begin
            pending <= 1'b1;
         end
      end
   end

   assign value = value_q;
   assign req   = room;

endmodule

// File: tb/tb_decoder.sv
// Bench for decoder: bit-queue reference model, per-cycle compare, directed plus random stimulus.
// Latency: model updates on each rising edge; outputs compared on the falling edge.
// Backpressure: writes are issued regardless of req so dropped words are exercised.
module tb_decoder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [19:0] mem = '0;
   logic        req;
   logic [7:0]  value;

   int errors = 0;
   int checks = 0;

   decoder dut (
      .clk   (clk),
      .reset (reset),
      .mem   (mem),
      .read  (read),
      .write (write),
      .req   (req),
      .value (value)
   );

   always #5 clk = ~clk;

   // Reference model: the buffer is a plain queue of bits, oldest bit first.
   bit         mq[$];
   bit         m_pend = 1'b0;
   logic [7:0] m_last = '0;
   logic [7:0] m_val = '0;

   function automatic int field(input int lo, input int n);
      int v;
      v = 0;
      for (int i = 0; i < n; i++) begin
         if (mq[lo + i]) v += (1 << i);
      end
      return v;
   endfunction

   always @(posedge clk or posedge reset) begin
      int pre;
      int tag;
      int len;
      bit want;
      logic [7:0] v;
      if (reset) begin
         mq.delete();
         m_pend = 1'b0;
         m_last = '0;
         m_val  = '0;
      end else begin
         pre  = mq.size();
         want = read || m_pend;
         tag  = 0;
         len  = 2;
         if (pre >= 2) begin
            tag = int'(mq[0]) + 2 * int'(mq[1]);
            len = (tag == 1) ? 6 : (tag == 2) ? 10 : 2;
         end
         if (want && pre >= 2 && pre >= len) begin
            case (tag)
               0:       v = 8'd0;
               1:       v = 8'(field(2, 4));
               2:       v = 8'(field(2, 8));
               default: v = m_last;
            endcase
            m_val  = v;
            m_last = v;
            for (int i = 0; i < len; i++) void'(mq.pop_front());
            m_pend = 1'b0;
         end else if (want) begin
            m_pend = 1'b1;
         end
         if (write && pre <= 20) begin
            for (int i = 0; i < 20; i++) mq.push_back(mem[i]);
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      checks++;
      if (value !== m_val) begin
         errors++;
         $display("FAIL model_value t=%0t got=%0d want=%0d", $time, value, m_val);
      end
      checks++;
      if (req !== (mq.size() <= 20)) begin
         errors++;
         $display("FAIL model_req t=%0t got=%0b want=%0b", $time, req, (mq.size() <= 20));
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   task automatic step(input bit r, input bit w, input logic [19:0] m);
      read  = r;
      write = w;
      mem   = m;
      @(posedge clk);
      @(negedge clk);
      read  = 1'b0;
      write = 1'b0;
   endtask

   task automatic pulse_reset();
      #2 reset = 1'b1;
      @(negedge clk);
      #2 reset = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("reset_value", int'(value), 0);
      chk("reset_req", int'(req), 1);

      // First word, then long / short / repeat / zero.
      step(0, 1, 20'h39606);
      chk("req_at_fill20", int'(req), 1);
      step(1, 0, '0); chk("w1_long", int'(value), 129);
      step(1, 0, '0); chk("w1_short", int'(value), 9);
      step(1, 0, '0); chk("w1_repeat", int'(value), 9);
      step(1, 0, '0); chk("w1_zero", int'(value), 0);

      // Two words back to back; third symbol straddles them.
      step(0, 1, 20'hA1642);
      step(0, 1, 20'h011BF);
      chk("req_full", int'(req), 0);
      step(1, 0, '0); chk("w2_long", int'(value), 144);
      step(1, 0, '0); chk("w2_short", int'(value), 1);
      step(1, 0, '0); chk("w2_straddle", int'(value), 254);
      step(1, 0, '0); chk("w2_long2", int'(value), 17);
      step(1, 0, '0); chk("w2_zero1", int'(value), 0);
      step(1, 0, '0); chk("w2_zero2", int'(value), 0);

      // Pending long literal waits for the next word; extra read merges.
      step(0, 1, 20'hA1642);
      step(1, 0, '0); chk("p_long", int'(value), 144);
      step(1, 0, '0); chk("p_short", int'(value), 1);
      step(1, 0, '0); chk("p_hold1", int'(value), 1);
      step(0, 0, '0); chk("p_hold2", int'(value), 1);
      step(1, 0, '0); chk("p_merged", int'(value), 1);
      step(0, 1, 20'h011BF); chk("p_write_edge", int'(value), 1);
      step(0, 0, '0); chk("p_resolved", int'(value), 254);
      step(0, 0, '0); chk("p_not_queued", int'(value), 254);
      step(1, 0, '0); chk("p_long2", int'(value), 17);
      step(1, 0, '0);
      step(1, 0, '0);

      // Write into a full buffer is dropped.
      step(0, 1, 20'h39606);
      step(0, 1, 20'hA1642);
      chk("d_req_full", int'(req), 0);
      step(0, 1, 20'h011BF);
      chk("d_req_still0", int'(req), 0);
      step(1, 0, '0); chk("d_v129", int'(value), 129); chk("d_req30", int'(req), 0);
      step(1, 0, '0); chk("d_v9", int'(value), 9);
      step(1, 0, '0); chk("d_v9r", int'(value), 9); chk("d_req22", int'(req), 0);
      step(1, 0, '0); chk("d_v0", int'(value), 0); chk("d_req20", int'(req), 1);
      step(1, 0, '0); chk("d_v144", int'(value), 144);
      step(1, 0, '0); chk("d_v1", int'(value), 1);

      // Reset mid-stream clears buffer, pending and last.
      pulse_reset();
      chk("r_value", int'(value), 0);
      chk("r_req", int'(req), 1);
      step(1, 1, 20'h00057); chk("r_rw_empty", int'(value), 0);
      step(0, 0, '0); chk("r_repeat", int'(value), 0);
      step(1, 0, '0); chk("r_short5", int'(value), 5);

      // Randomized traffic, occasional reset.
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 599) == 0) begin
            pulse_reset();
         end else begin
            step($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 35, 20'($urandom));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
